// File: rtl/keypad_scan_deb_pkg.sv
// Shared definitions for the keypad scanner.
//   EVT_PRESS / EVT_RELEASE : polarity of the event press flag
//   upd_state_e             : per-column debounce update sequencer states
//   idx_w()                 : width needed to index n items (never below 1)
package keypad_scan_deb_pkg;

    localparam logic EVT_PRESS   = 1'b1;
    localparam logic EVT_RELEASE = 1'b0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_UPD  = 1'b1
    } upd_state_e;

    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/keypad_scan_deb_evt_fifo.sv
// Small synchronous FIFO holding key events.
//   clk, rst   : clock, asynchronous active-high reset (pointers only)
//   push       : write push_data if there is room (or a pop frees a slot)
//   push_data  : entry to write
//   pop        : drop the head entry (ignored when empty)
//   head_data  : current head entry (undefined storage when empty)
//   full/empty : occupancy flags
module evt_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              do_push;
    logic              do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign head_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is never reset; empty gates its visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/keypad_scan_deb.sv
// Matrix keypad scanner with per-key debounce and a press/release event stream.
//   clk, rst   : clock, asynchronous active-high reset
//   key_col    : column drive, active-low one-hot
//   key_row    : row sense, active-low, asynchronous to clk
//   key_state  : debounced bitmap, bit row*COLS+col, 1 = pressed
//   evt_valid  : event FIFO head is valid
//   evt_ready  : consumer takes the head event
//   evt_code   : key index of the head event
//   evt_press  : 1 = press, 0 = release
//   ovf        : sticky, an event was dropped on a full FIFO
//   ovf_clr    : clears ovf (a simultaneous new drop keeps it set)
module keypad_scan_deb
    import keypad_scan_deb_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_FRAMES = 3,
    parameter int EVT_DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic [COLS-1:0]              key_col,
    input  logic [ROWS-1:0]              key_row,
    output logic [ROWS*COLS-1:0]         key_state,
    output logic                         evt_valid,
    input  logic                         evt_ready,
    output logic [idx_w(ROWS*COLS)-1:0]  evt_code,
    output logic                         evt_press,
    output logic                         ovf,
    input  logic                         ovf_clr
);

    localparam int NK  = ROWS * COLS;
    localparam int KW  = idx_w(NK);
    localparam int DW  = idx_w(SCAN_DIV);
    localparam int CLW = idx_w(COLS);
    localparam int RW  = idx_w(ROWS);
    localparam int CW  = idx_w(DEB_FRAMES + 1);

    logic [ROWS-1:0] row_s1_q, row_s1_d;
    logic [ROWS-1:0] row_s2_q, row_s2_d;
    logic [DW-1:0]   div_q, div_d;
    logic [CLW-1:0]  col_q, col_d;
    logic [ROWS-1:0] row_smp_q, row_smp_d;
    logic [CLW-1:0]  upd_col_q, upd_col_d;
    upd_state_e      state_q, state_d;
    logic [RW-1:0]   row_it_q, row_it_d;
    logic [NK-1:0]   key_state_q, key_state_d;
    logic [CW-1:0]   cnt_q [NK];
    logic [CW-1:0]   cnt_d [NK];
    logic            ovf_q, ovf_d;

    logic            capture;
    logic [KW-1:0]   upd_key;
    logic            raw;
    logic            push;
    logic [KW:0]     push_data;
    logic            pop_fire;
    logic            drop;
    logic [KW:0]     fifo_head;
    logic            fifo_full;
    logic            fifo_empty;

    assign capture  = (div_q == DW'(SCAN_DIV - 1));
    assign upd_key  = KW'(int'(row_it_q) * COLS + int'(upd_col_q));
    assign pop_fire = !fifo_empty && evt_ready;
    // The FIFO accepts a push into a full queue only when a pop frees a slot.
    assign drop     = push && fifo_full && !pop_fire;

    always_comb begin
        // Two-flop synchroniser on the inverted (active-high) rows.
        row_s1_d    = ~key_row;
        row_s2_d    = row_s1_q;

        div_d       = div_q + DW'(1);
        col_d       = col_q;
        row_smp_d   = row_smp_q;
        upd_col_d   = upd_col_q;
        state_d     = state_q;
        row_it_d    = row_it_q;
        key_state_d = key_state_q;
        cnt_d       = cnt_q;
        raw         = 1'b0;
        push        = 1'b0;
        push_data   = '0;

        // Column advances on the same edge the divider wraps.
        if (capture) begin
            div_d = '0;
            col_d = (col_q == CLW'(COLS - 1)) ? '0 : col_q + CLW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (capture) begin
                    state_d   = ST_UPD;
                    row_it_d  = '0;
                    row_smp_d = row_s2_q;
                    upd_col_d = col_q;
                end
            end
            ST_UPD: begin
                // One key per cycle: the sampled column, walking rows upward.
                raw = row_smp_q[row_it_q];
                if (raw == key_state_q[upd_key]) begin
                    cnt_d[upd_key] = '0;
                end else if (int'(cnt_q[upd_key]) + 1 == DEB_FRAMES) begin
                    key_state_d[upd_key] = raw;
                    cnt_d[upd_key]       = '0;
                    push                 = 1'b1;
                    push_data            = {upd_key, raw ? EVT_PRESS : EVT_RELEASE};
                end else begin
                    cnt_d[upd_key] = cnt_q[upd_key] + CW'(1);
                end
                if (row_it_q == RW'(ROWS - 1)) state_d  = ST_IDLE;
                else                          row_it_d = row_it_q + RW'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // Set wins over clear.
        ovf_d = drop || (ovf_q && !ovf_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_s1_q    <= '0;
            row_s2_q    <= '0;
            div_q       <= '0;
            col_q       <= '0;
            row_smp_q   <= '0;
            upd_col_q   <= '0;
            state_q     <= ST_IDLE;
            row_it_q    <= '0;
            key_state_q <= '0;
            cnt_q       <= '{default: '0};
            ovf_q       <= 1'b0;
        end else begin
            row_s1_q    <= row_s1_d;
            row_s2_q    <= row_s2_d;
            div_q       <= div_d;
            col_q       <= col_d;
            row_smp_q   <= row_smp_d;
            upd_col_q   <= upd_col_d;
            state_q     <= state_d;
            row_it_q    <= row_it_d;
            key_state_q <= key_state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    evt_fifo #(
        .DATA_W (KW + 1),
        .DEPTH  (EVT_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop_fire),
        .head_data (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign key_col   = ~(COLS'(1) << col_q);
    assign key_state = key_state_q;
    assign evt_valid = !fifo_empty;
    // Head fields read as zero while the FIFO is empty.
    assign evt_code  = fifo_empty ? '0 : fifo_head[KW:1];
    assign evt_press = !fifo_empty && fifo_head[0];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_keypad_scan_deb.sv
module tb_keypad_scan_deb;

    localparam int ROWS       = 4;
    localparam int COLS       = 4;
    localparam int SCAN_DIV   = 8;
    localparam int DEB_FRAMES = 3;
    localparam int EVT_DEPTH  = 4;
    localparam int NK         = ROWS * COLS;
    localparam int FRAME      = COLS * SCAN_DIV;

    logic            clk = 1'b0;
    logic            rst;
    logic [COLS-1:0] key_col;
    logic [ROWS-1:0] key_row;
    logic [NK-1:0]   key_state;
    logic            evt_valid;
    logic            evt_ready;
    logic [3:0]      evt_code;
    logic            evt_press;
    logic            ovf;
    logic            ovf_clr;

    always #5 clk = ~clk;

    keypad_scan_deb #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .SCAN_DIV   (SCAN_DIV),
        .DEB_FRAMES (DEB_FRAMES),
        .EVT_DEPTH  (EVT_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_col   (key_col),
        .key_row   (key_row),
        .key_state (key_state),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_code  (evt_code),
        .evt_press (evt_press),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    // Virtual keypad: a pressed key shorts its row to the driven (low) column.
    logic [NK-1:0] pressed;
    always_comb begin
        key_row = '1;
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (!key_col[c] && pressed[r*COLS+c]) key_row[r] = 1'b0;
    end

    typedef struct packed {
        logic [3:0] code;
        logic       press;
    } evt_t;

    int        compared   = 0;
    int        mismatched = 0;
    int        k          = 0;      // clock edges since reset release
    bit        in_rst     = 1'b1;
    logic [NK-1:0] model_ks = '0;   // expected debounced bitmap
    bit        ovf_exp    = 1'b0;
    bit        hist [NK][$];        // samples seen since the key last flipped
    evt_t      exp_q [$];           // expected events, in FIFO order

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // A key flips once its last DEB_FRAMES samples since the previous flip
    // all disagree with its debounced state.
    task automatic model_sample();
        int  col;
        int  key;
        int  n;
        bit  s;
        bit  flip;
        evt_t e;
        col = ((k - 1) / SCAN_DIV) % COLS;
        for (int r = 0; r < ROWS; r++) begin
            key = r * COLS + col;
            s   = pressed[key];
            hist[key].push_back(s);
            n    = hist[key].size();
            flip = (n >= DEB_FRAMES);
            for (int j = 1; j <= DEB_FRAMES; j++)
                if (flip && hist[key][n-j] == model_ks[key]) flip = 1'b0;
            if (flip) begin
                model_ks[key] = s;
                hist[key].delete();
                if (exp_q.size() >= EVT_DEPTH) begin
                    ovf_exp = 1'b1;
                end else begin
                    e.code  = 4'(key);
                    e.press = s;
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        model_ks = '0;
        ovf_exp  = 1'b0;
        for (int i = 0; i < NK; i++) hist[i].delete();
    endtask

    // Rows are captured on edges where k is a multiple of SCAN_DIV.
    task automatic step();
        @(posedge clk);
        k++;
        #1;
        if (k % SCAN_DIV == 0) model_sample();
    endtask

    task automatic run_frames(input int n);
        repeat (n * FRAME) step();
    endtask

    task automatic align_frame();
        while (k % FRAME != 2) step();
    endtask

    // Monitor / scoreboard.
    initial begin
        evt_t e;
        logic [COLS-1:0] exp_col;
        forever begin
            @(negedge clk);
            if (!in_rst) begin
                if (k % SCAN_DIV == 4) begin
                    exp_col = ~(COLS'(1) << ((k / SCAN_DIV) % COLS));
                    check("key_col", key_col, exp_col);
                end
                if (k % SCAN_DIV == 6) begin
                    check("key_state", key_state, model_ks);
                    check("ovf", ovf, ovf_exp);
                end
                if (evt_valid && evt_ready) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_evt: got code %0d press %0d, expected no event at t=%0t",
                                 evt_code, evt_press, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("evt_code", evt_code, e.code);
                        check("evt_press", evt_press, e.press);
                    end
                end
            end
        end
    end

    // Stimulus.
    initial begin
        int idx;
        int len;
        rst       = 1'b1;
        pressed   = '0;
        evt_ready = 1'b1;
        ovf_clr   = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_key_col", key_col, 4'b1110);
        check("rst_key_state", key_state, 0);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_code", evt_code, 0);
        check("rst_evt_press", evt_press, 0);
        check("rst_ovf", ovf, 0);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        in_rst = 1'b0;
        k      = 0;
        step();
        step();

        // Idle scanning.
        run_frames(10);

        // Key 9 (row 2, column 1): press then release.
        pressed[9] = 1'b1;
        run_frames(5);
        pressed[9] = 1'b0;
        run_frames(5);

        // Two-frame glitch on key 0.
        pressed[0] = 1'b1;
        run_frames(2);
        pressed[0] = 1'b0;
        run_frames(4);

        // Fill the FIFO with the consumer stalled.
        evt_ready = 1'b0;
        pressed   = '0;
        pressed[0] = 1'b1; pressed[5] = 1'b1; pressed[10] = 1'b1; pressed[15] = 1'b1;
        run_frames(5);
        @(negedge clk);
        check("stall_valid", evt_valid, 1);
        check("stall_code", evt_code, 0);
        check("stall_press", evt_press, 1);
        check("stall_ovf", ovf, 0);

        // One more key while full: dropped, ovf set, head unchanged.
        align_frame();
        pressed[3] = 1'b1;
        run_frames(4);
        @(negedge clk);
        check("full_ovf", ovf, 1);
        check("full_key3", key_state[3], 1);
        check("full_code", evt_code, 0);
        check("full_valid", evt_valid, 1);
        while (k % SCAN_DIV != 5) step();
        ovf_clr = 1'b1;
        ovf_exp = 1'b0;
        step();
        ovf_clr = 1'b0;
        @(negedge clk);
        check("ovf_cleared", ovf, 0);

        // Reset in the middle of a column update with events queued.
        while (k % SCAN_DIV != 2) step();
        check("pre_rst_valid", evt_valid, 1);
        rst    = 1'b1;
        in_rst = 1'b1;
        model_clear();
        #2;
        check("mid_rst_key_col", key_col, 4'b1110);
        check("mid_rst_key_state", key_state, 0);
        check("mid_rst_evt_valid", evt_valid, 0);
        check("mid_rst_evt_code", evt_code, 0);
        check("mid_rst_evt_press", evt_press, 0);
        check("mid_rst_ovf", ovf, 0);
        pressed   = '0;
        evt_ready = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        in_rst = 1'b0;
        k      = 0;
        @(negedge clk);
        check("post_rst_col", key_col, 4'b1110);
        step();
        step();

        // Randomised key activity with a bursty consumer.
        for (int ep = 0; ep < 30; ep++) begin
            if ($urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, NK - 1);
                pressed[idx] = ~pressed[idx];
            end
            len = FRAME * $urandom_range(1, 3);
            for (int i = 0; i < len; i++) begin
                step();
                evt_ready = ($urandom_range(0, 3) != 0);
            end
        end

        // Drain.
        evt_ready = 1'b1;
        run_frames(6);
        @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL drain: got %0d events still outstanding, expected 0", exp_q.size());
        end
        check("drain_valid", evt_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/keypad_scan_deb.md
Name: keypad_scan_deb

Overview:
- Parametrised matrix-keypad scanner, next generation of the fixed 4x4 scanner.
- Drives one active-low column at a time, synchronises the active-low row inputs, and debounces every key per frame.
- Publishes a debounced key bitmap plus a valid/ready stream of press/release events buffered in a small FIFO.
- Sits between the board keypad pins and the control/display logic.

Parameters:
- ROWS, 4, number of row inputs (2..8)
- COLS, 4, number of column outputs (2..8)
- SCAN_DIV, 1000, clk cycles each column is driven; must be >= ROWS+3
- DEB_FRAMES, 3, consecutive identical samples needed to change a key's debounced state (1..15)
- EVT_DEPTH, 4, event FIFO depth; power of 2, >= 2

Ports:
- clk  in  1  clock
- rst  in  1  reset
- key_col  out  COLS  column drive, active-low one-hot
- key_row  in  ROWS  row sense, active-low (pulled up), asynchronous
- key_state  out  ROWS*COLS  debounced bitmap, 1 = pressed; bit index = row*COLS+col
- evt_valid  out  1  FIFO head holds an event
- evt_ready  in  1  consumer accepts the head event
- evt_code  out  clog2(ROWS*COLS)  key index of head event
- evt_press  out  1  1 = press, 0 = release
- ovf  out  1  sticky flag: an event was dropped because the FIFO was full
- ovf_clr  in  1  clears ovf

Behaviour:
- Reset: rst is asynchronous and active-high; clk is the clock.
  - key_col = ~1 (column 0 active); divider = 0; col index = 0; all debounce counters = 0.
  - key_state = 0; FIFO empty; evt_valid = 0; evt_code = 0; evt_press = 0; ovf = 0.
  - Reset mid-scan or mid-update abandons all work; no event is emitted for state cleared by reset.
- Row synchroniser: two flops on ~key_row before any use.
- Scan timing: the divider counts 0..SCAN_DIV-1 while column c is driven.
  - At count SCAN_DIV-1, capture the synchronised rows into row_smp.
  - On the next cycle (count wraps to 0), advance to column (c+1) mod COLS.
  - One frame = COLS*SCAN_DIV cycles.
- Update FSM states: IDLE, UPD.
  - IDLE -> UPD on the capture cycle; the row iterator starts at 0.
  - UPD processes one row per cycle for the just-sampled column. After row ROWS-1 it returns to IDLE.
  - UPD therefore finishes well before the next capture.
- Per-key debounce (key k, raw r = row_smp[row]):
  - If r == key_state[k]: cnt <= 0.
  - Else if cnt+1 == DEB_FRAMES: key_state[k] <= r, cnt <= 0, push event {k, r}.
  - Else: cnt <= cnt+1.
  - With DEB_FRAMES = 1, the first differing sample flips the state.
  - A glitch shorter than DEB_FRAMES samples never changes key_state and never emits an event.
- Latency: key_state updates in the UPD cycle of the DEB_FRAMES-th consecutive differing sample. evt_valid rises the following cycle if the FIFO was empty.
- At most one push per cycle, by construction.
- FIFO rules:
  - Pop occurs when evt_valid && evt_ready.
  - Push when not full: accepted.
  - Push when full without a simultaneous pop: event dropped, ovf <= 1. key_state still updates.
  - Push and pop in the same cycle while full: both succeed, no overflow.
  - Push and pop in the same cycle while empty: the head becomes the pushed event next cycle.
  - Head outputs are stable while evt_valid && !evt_ready.
- ovf_clr together with a new overflow in the same cycle: ovf stays 1 (set wins).
- Several simultaneous keys are all reported, one event per key, in column order, then ascending row.

Decomposition:
- Shared package holds:
  - EVT_PRESS/EVT_RELEASE constants
  - Update-FSM state encoding (IDLE, UPD)
  - the clog2-based width function for key index and counter widths
- One sub-module, evt_fifo: a parametrised synchronous FIFO (data width, depth) with push/pop/full/empty.
- Scanner, synchroniser and debounce stay in the top module.

Test Plan (bench: ROWS=4, COLS=4, SCAN_DIV=8, DEB_FRAMES=3, EVT_DEPTH=4):
- Reset release, no keys -> key_col sequence 1110, 1101, 1011, 0111, each held 8 cycles; key_state = 0, evt_valid = 0 for 10 frames.
- Hold row 2 low whenever column 1 is driven, evt_ready = 1 -> key_state[9] = 1 after the 3rd column-1 sample. Exactly one event {code = 9, press = 1}; on release, exactly one event {9, 0} after 3 frames.
- Row 0 low during column 0 for only 2 consecutive frames -> no change in key_state, no event.
- Keys 0, 5, 10 and 15 held, evt_ready = 0 -> 4 press events queued in order 0, 5, 10, 15. ovf = 0; evt_code holds 0 while stalled.
- Continue with evt_ready = 0 and press key 3 -> key_state[3] = 1, ovf = 1, FIFO content unchanged. ovf_clr pulse -> ovf = 0.
- Assert rst mid-UPD while events are queued -> all outputs at reset values next cycle; after release, scanning resumes at column 0.
